// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Data-memory access controller between the address decoder and a
//   synchronous-read 2048x32 data RAM. Handles byte/halfword/word loads with
//   sign or zero extension, single-cycle word stores, two-cycle
//   read-modify-write sub-word stores, and address-error detection.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   memRead/memWrite  : CPU load / store request (both together = error)
//   memSize, signExt  : access size (00 B, 01 H, 10 W, 11 rsvd), load extension
//   virtualAddress    : CPU address, [1:0] is the byte offset
//   physicalAddress   : decoder word index; invalidAddress: decoder fault
//   writeData         : right-justified store data
//   readData          : load result, valid in the load completion cycle only
//   stall, addrError  : pipeline hold, one-cycle error pulse
//   ramAddr/ramWe/ramWdata/ramRdata : RAM side (read data one cycle late)
//   errClear, errSticky, badVAddr   : sticky error capture
//
// Configuration
//   DMEM_ERR_STICKY_EN : when defined, errSticky/badVAddr capture the first
//                        error since the last errClear; otherwise both are 0.
module dmem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        signExt,
  input  logic [31:0] virtualAddress,
  input  logic [10:0] physicalAddress,
  input  logic        invalidAddress,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        addrError,
  output logic [10:0] ramAddr,
  output logic        ramWe,
  output logic [31:0] ramWdata,
  input  logic [31:0] ramRdata,
  input  logic        errClear,
  output logic        errSticky,
  output logic [31:0] badVAddr
);

  typedef enum logic [1:0] {IDLE, LD_WAIT, RMW_WR} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01,
                            SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_t;

  state_t      state_q, state_d;
  logic        latch_en;
  logic [10:0] addr_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [15:0] data_q;

  logic        req, bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign req = memRead | memWrite;
  assign bad = (memRead & memWrite) | invalidAddress
             | (memSize == SZ_RSVD)
             | ((memSize == SZ_HALF) & virtualAddress[0])
             | ((memSize == SZ_WORD) & (virtualAddress[1:0] != 2'b00));

  // Little-endian lane extraction from the word returned by the RAM.
  assign byte_sel = ramRdata[{off_q, 3'b000} +: 8];
  assign half_sel = off_q[1] ? ramRdata[31:16] : ramRdata[15:0];

  always_comb begin
    load_ext = ramRdata;
    case (size_q)
      SZ_BYTE: load_ext = {{24{sext_q & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_ext = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_ext = ramRdata;
    endcase
  end

  always_comb begin
    merged = ramRdata;
    if (size_q == SZ_BYTE)
      merged[{off_q, 3'b000} +: 8] = data_q[7:0];
    else
      merged[{off_q[1], 4'b0000} +: 16] = data_q;
  end

  // Outputs are held at their reset values while rst is high so that a reset
  // landing in RMW_WR never produces a partial write.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    addrError = 1'b0;
    ramWe     = 1'b0;
    ramAddr   = '0;
    ramWdata  = '0;
    readData  = '0;
    latch_en  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (bad) begin
              addrError = 1'b1;
            end else if (memRead) begin
              ramAddr  = physicalAddress;
              stall    = 1'b1;
              latch_en = 1'b1;
              state_d  = LD_WAIT;
            end else if (memSize == SZ_WORD) begin
              ramAddr  = physicalAddress;
              ramWe    = 1'b1;
              ramWdata = writeData;
            end else begin
              ramAddr  = physicalAddress;
              stall    = 1'b1;
              latch_en = 1'b1;
              state_d  = RMW_WR;
            end
          end
        end
        LD_WAIT: begin
          ramAddr  = addr_q;
          readData = load_ext;
          state_d  = IDLE;
        end
        RMW_WR: begin
          ramAddr  = addr_q;
          ramWe    = 1'b1;
          ramWdata = merged;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        addr_q <= physicalAddress;
        off_q  <= virtualAddress[1:0];
        size_q <= memSize;
        sext_q <= signExt;
        data_q <= writeData[15:0];
      end
    end
  end

`ifdef DMEM_ERR_STICKY_EN
  logic        sticky_q;
  logic [31:0] bad_q;

  // A new error beats a simultaneous clear, and re-captures the address.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
      bad_q    <= '0;
    end else if (addrError && (!sticky_q || errClear)) begin
      sticky_q <= 1'b1;
      bad_q    <= virtualAddress;
    end else if (errClear) begin
      sticky_q <= 1'b0;
      bad_q    <= '0;
    end
  end

  assign errSticky = sticky_q;
  assign badVAddr  = bad_q;
`else
  logic unused_sticky_inputs;
  assign unused_sticky_inputs = ^{errClear, virtualAddress[31:2]};
  assign errSticky = 1'b0;
  assign badVAddr  = '0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with a behavioural synchronous RAM.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite, signExt, invalidAddress, errClear;
  logic [1:0]  memSize;
  logic [31:0] virtualAddress, writeData, readData, ramWdata, ramRdata, badVAddr;
  logic [10:0] physicalAddress, ramAddr;
  logic        stall, addrError, ramWe, errSticky;

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
    .memSize(memSize), .signExt(signExt), .virtualAddress(virtualAddress),
    .physicalAddress(physicalAddress), .invalidAddress(invalidAddress),
    .writeData(writeData), .readData(readData), .stall(stall),
    .addrError(addrError), .ramAddr(ramAddr), .ramWe(ramWe),
    .ramWdata(ramWdata), .ramRdata(ramRdata), .errClear(errClear),
    .errSticky(errSticky), .badVAddr(badVAddr)
  );

  // Synchronous-read RAM, read-before-write.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (ramWe) mem[ramAddr] <= ramWdata;
    ramRdata <= mem[ramAddr];
  end

`ifdef DMEM_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] va_of(input int unsigned idx, input int unsigned off);
    return 32'h1001_0000 + 32'(idx * 4) + 32'(off);
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sx, input logic [31:0] va, input int unsigned idx,
                       input logic inv, input logic [31:0] wd);
    memRead = rd; memWrite = wr; memSize = sz; signExt = sx;
    virtualAddress = va; physicalAddress = 11'(idx);
    invalidAddress = inv; writeData = wd;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    drive(0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h0);
    errClear = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".stall"}, 32'(stall), 32'h0);
    check({tag, ".addrError"}, 32'(addrError), 32'h0);
    check({tag, ".ramWe"}, 32'(ramWe), 32'h0);
    check({tag, ".ramAddr"}, 32'(ramAddr), 32'h0);
    check({tag, ".ramWdata"}, ramWdata, 32'h0);
    check({tag, ".readData"}, readData, 32'h0);
    check({tag, ".errSticky"}, 32'(errSticky), 32'h0);
    check({tag, ".badVAddr"}, badVAddr, 32'h0);
  endtask

  task automatic word_store(input int unsigned idx, input logic [31:0] d);
    @(posedge clk); #1;
    drive(0, 1, 2'b10, 0, va_of(idx, 0), idx, 0, d);
    @(negedge clk);
    check("wst.ramWe", 32'(ramWe), 32'h1);
    check("wst.ramAddr", 32'(ramAddr), idx);
    check("wst.ramWdata", ramWdata, d);
    check("wst.stall", 32'(stall), 32'h0);
  endtask

  task automatic load(input int unsigned idx, input int unsigned off, input logic [1:0] sz,
                      input logic sx, input logic [31:0] expected);
    @(posedge clk); #1;
    drive(1, 0, sz, sx, va_of(idx, off), idx, 0, 32'h0);
    exp_q.push_back(expected);
    @(negedge clk);
    check("ld.stall_issue", 32'(stall), 32'h1);
    check("ld.ramWe_issue", 32'(ramWe), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ld.stall_done", 32'(stall), 32'h0);
    check("ld.readData", readData, exp_q.pop_front());
  endtask

  task automatic sub_store(input int unsigned idx, input int unsigned off, input logic [1:0] sz,
                           input logic [31:0] d, input logic [31:0] exp_word);
    @(posedge clk); #1;
    drive(0, 1, sz, 0, va_of(idx, off), idx, 0, d);
    exp_q.push_back(exp_word);
    @(negedge clk);
    check("rmw.stall_read", 32'(stall), 32'h1);
    check("rmw.ramWe_read", 32'(ramWe), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rmw.ramWe_wr", 32'(ramWe), 32'h1);
    check("rmw.ramAddr", 32'(ramAddr), idx);
    check("rmw.ramWdata", ramWdata, exp_q.pop_front());
    check("rmw.stall_wr", 32'(stall), 32'h0);
  endtask

  task automatic err_req(input string tag, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic [31:0] va, input logic inv,
                         input logic clr);
    @(posedge clk); #1;
    drive(rd, wr, sz, 0, va, 3, inv, 32'h5A5A_5A5A);
    errClear = clr;
    @(negedge clk);
    check({tag, ".addrError"}, 32'(addrError), 32'h1);
    check({tag, ".ramWe"}, 32'(ramWe), 32'h0);
    check({tag, ".stall"}, 32'(stall), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    errClear = 1'b0;
    drive(0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Word store then word load
    word_store(5, 32'hDEAD_BEEF);
    idle();
    check("wst.ramWe_one_cycle", 32'(ramWe), 32'h0);
    load(5, 0, 2'b10, 0, 32'hDEAD_BEEF);
    idle();
    check("ld.readData_after", readData, 32'h0);

    // Byte/halfword loads with extension
    word_store(6, 32'h80FF_7F01);
    load(6, 3, 2'b00, 1, 32'hFFFF_FF80);
    load(6, 2, 2'b00, 0, 32'h0000_00FF);   // back-to-back with the previous load
    load(6, 0, 2'b00, 1, 32'h0000_0001);
    load(6, 1, 2'b00, 1, 32'h0000_007F);
    load(6, 2, 2'b01, 1, 32'hFFFF_80FF);
    load(6, 0, 2'b01, 0, 32'h0000_7F01);

    // Sub-word stores via read-modify-write
    word_store(7, 32'h1122_3344);
    sub_store(7, 2, 2'b01, 32'hFFFF_ABCD, 32'hABCD_3344);
    sub_store(7, 1, 2'b00, 32'h0000_0055, 32'hABCD_5544);
    load(7, 0, 2'b10, 0, 32'hABCD_5544);
    idle();

    // Address errors
    err_req("err_wmis", 1, 0, 2'b10, 32'h1001_0002, 0, 0);
    err_req("err_inv", 1, 0, 2'b10, 32'h1001_0000, 1, 0);
    err_req("err_both", 1, 1, 2'b10, 32'h1001_0000, 0, 0);
    err_req("err_rsvd", 0, 1, 2'b11, 32'h1001_0000, 0, 0);
    err_req("err_hmis", 0, 1, 2'b01, 32'h1001_0003, 0, 0);
    idle();
    check("err.addrError_pulse", 32'(addrError), 32'h0);
    load(5, 0, 2'b10, 0, 32'hDEAD_BEEF);     // no write happened during errors

    // Reset during RMW_WR
    idle();
    rst = 1'b1; idle(); #1 rst = 1'b0;       // clear sticky state before the test
    word_store(8, 32'h9988_7766);
    @(posedge clk); #1;
    drive(0, 1, 2'b01, 0, va_of(8, 0), 8, 0, 32'h0000_1234);
    @(negedge clk);
    check("rst_rmw.stall", 32'(stall), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_rmw.ramWe", 32'(ramWe), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    check_reset_outputs("rst_rmw");
    load(8, 0, 2'b10, 0, 32'h9988_7766);

    // Sticky error capture
    idle();
    err_req("stk_e1", 1, 0, 2'b01, 32'h1001_0001, 0, 0);
    err_req("stk_e2", 1, 0, 2'b10, 32'h7FFF_F003, 0, 0);
    idle();
    check("stk.errSticky", 32'(errSticky), STICKY ? 32'h1 : 32'h0);
    check("stk.badVAddr", badVAddr, STICKY ? 32'h1001_0001 : 32'h0);
    @(posedge clk); #1 errClear = 1'b1;
    idle();
    check("stk.clear_flag", 32'(errSticky), 32'h0);
    check("stk.clear_addr", badVAddr, 32'h0);
    err_req("stk_e3", 1, 0, 2'b01, 32'h1001_0001, 0, 0);
    err_req("stk_e4clr", 1, 0, 2'b10, 32'h7FFF_F003, 0, 1);
    idle();
    check("stk.err_beats_clear", 32'(errSticky), STICKY ? 32'h1 : 32'h0);
    check("stk.err_clear_addr", badVAddr, STICKY ? 32'h7FFF_F003 : 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
